// File: rtl/round_pack.sv
// rtl/round_pack.sv - two-stage IEEE-754 single round-and-pack with valid/ready on both ends
// Optional feature macro: ROUND_MODES_EN adds rm[1:0] (00 RNE, 01 RTZ, 10 RUP, 11 RDN).
module round_pack #(
    parameter int EXP_W   = 10,
    parameter int MAX_EXP = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign_in,
    input  logic [EXP_W-1:0] Ez_add,
    input  logic [24:0]      normalised_output,
    input  logic             sticky_in,
    input  logic [4:0]       SHL,
    input  logic             ovf,
`ifdef ROUND_MODES_EN
    input  logic [1:0]       rm,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [2:0]       flags
);
    // One extra bit over the stage-1 exponent absorbs the rounding carry.
    localparam int EW = EXP_W + 2;

    logic             s1_valid;
    logic             s1_sign;
    logic             s1_sub;
    logic [EXP_W:0]   s1_e;
    logic [23:0]      s1_mant;
    logic             s1_inc;
    logic             s1_inexact;
    logic [1:0]       s1_rm;

    logic             s2_open;
    logic             s1_advancing;

    logic             guard;
    logic             inexact_d;
    logic             subnormal_d;
    logic [EXP_W:0]   e_norm_d;
    logic             inc_d;
    logic [1:0]       rm_d;

    logic [24:0]      sum;
    logic [23:0]      mant_r;
    logic [EW-1:0]    e_r;
    logic             e_ge_max;
    logic             e_le0;
    logic             sat;
    logic [31:0]      nxt_result;
    logic [2:0]       nxt_flags;

    assign s2_open      = !out_valid || out_ready;
    assign s1_advancing = s1_valid && s2_open;
    assign in_ready     = !s1_valid || s1_advancing;

    assign guard       = normalised_output[0];
    assign inexact_d   = guard | sticky_in;
    assign subnormal_d = Ez_add[EXP_W-1] | (Ez_add == '0);
    assign e_norm_d    = {Ez_add[EXP_W-1], Ez_add} + (EXP_W+1)'(ovf) - (EXP_W+1)'(SHL);

`ifdef ROUND_MODES_EN
    assign rm_d = rm;
`else
    assign rm_d = 2'b00;
`endif

    always_comb begin
        inc_d = guard & (normalised_output[1] | sticky_in);
        case (rm_d)
            2'b01:   inc_d = 1'b0;
            2'b10:   inc_d = inexact_d & ~sign_in;
            2'b11:   inc_d = inexact_d & sign_in;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_sub     <= 1'b0;
            s1_e       <= '0;
            s1_mant    <= '0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
            s1_rm      <= 2'b00;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= sign_in;
                s1_sub     <= subnormal_d;
                s1_e       <= subnormal_d ? '0 : e_norm_d;
                s1_mant    <= normalised_output[24:1];
                s1_inc     <= inc_d;
                s1_inexact <= inexact_d;
                s1_rm      <= rm_d;
            end
        end
    end

    assign sum      = {1'b0, s1_mant} + 25'(s1_inc);
    assign mant_r   = sum[24] ? sum[24:1] : sum[23:0];
    assign e_r      = {s1_e[EXP_W], s1_e} + EW'(sum[24]);
    assign e_ge_max = $signed(e_r) >= $signed(EW'(MAX_EXP));
    assign e_le0    = e_r[EW-1] | (e_r == '0);

    // Directed modes that round toward zero saturate to the largest finite value.
    assign sat = (s1_rm == 2'b01) | ((s1_rm == 2'b10) & s1_sign) | ((s1_rm == 2'b11) & ~s1_sign);

    always_comb begin
        nxt_result = '0;
        nxt_flags  = '0;
        if (s1_sub) begin
            nxt_result = {s1_sign, 7'd0, mant_r[23], mant_r[22:0]};
            nxt_flags  = {1'b0, ~mant_r[23] & s1_inexact, s1_inexact};
        end else if (e_ge_max) begin
            nxt_result = sat ? {s1_sign, 8'hFE, 23'h7FFFFF} : {s1_sign, 8'hFF, 23'h0};
            nxt_flags  = 3'b101;
        end else if (e_le0) begin
            nxt_result = {s1_sign, 31'h0};
            nxt_flags  = 3'b011;
        end else begin
            nxt_result = {s1_sign, e_r[7:0], mant_r[22:0]};
            nxt_flags  = {2'b00, s1_inexact};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (s2_open) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= nxt_result;
                flags  <= nxt_flags;
            end
        end
    end
endmodule

// File: tb/tb_round_pack.sv
// tb/tb_round_pack.sv - table-driven and randomized self-checking bench for round_pack
module tb_round_pack;
    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [9:0]  Ez_add;
    logic [24:0] normalised_output;
    logic        sticky_in;
    logic [4:0]  SHL;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;
`ifdef ROUND_MODES_EN
    logic [1:0]  rm = 2'b00;
`endif

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic        s;
        logic [9:0]  ez;
        logic [24:0] n;
        logic        st;
        logic [4:0]  shl;
        logic        ov;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    vec_t vecs[14];
    logic [34:0] exp_q[$];
    bit chk_ready = 0;
    int popped = 0;

    round_pack dut (
        .CLK(CLK),
        .RST(RST),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .sign_in(sign_in),
        .Ez_add(Ez_add),
        .normalised_output(normalised_output),
        .sticky_in(sticky_in),
        .SHL(SHL),
        .ovf(ovf),
`ifdef ROUND_MODES_EN
        .rm(rm),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .flags(flags)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: round-to-nearest-even on integers, then classify the final exponent.
    function automatic logic [34:0] model(input logic s, input logic [9:0] ez_bits, input logic [24:0] n,
                                          input logic st, input logic [4:0] shl, input logic ov);
        int ez, e, m;
        logic g, inx;
        logic [7:0] fld;
        ez  = int'($signed(ez_bits));
        m   = int'(n[24:1]);
        g   = n[0];
        inx = g | st;
        if (g && (st || (m % 2 == 1))) m = m + 1;
        if (ez <= 0) begin
            fld = (m >= 32'h800000) ? 8'd1 : 8'd0;
            return {1'b0, ((fld == 8'd0) && inx), inx, s, fld, m[22:0]};
        end
        e = ez + int'(ov) - int'(shl);
        if (m >= 32'h1000000) begin
            m = m / 2;
            e = e + 1;
        end
        if (e >= 255) return {3'b101, s, 8'hFF, 23'h0};
        if (e <= 0) return {3'b011, s, 31'h0};
        return {2'b00, inx, s, e[7:0], m[22:0]};
    endfunction

    task automatic drive_vec(input int i);
        sign_in = vecs[i].s;
        Ez_add = vecs[i].ez;
        normalised_output = vecs[i].n;
        sticky_in = vecs[i].st;
        SHL = vecs[i].shl;
        ovf = vecs[i].ov;
    endtask

    task automatic rand_inputs();
        int cat;
        cat = int'($urandom_range(0, 9));
        sign_in = 1'($urandom);
        sticky_in = 1'($urandom);
        ovf = 1'($urandom);
        SHL = 5'($urandom);
        normalised_output = {1'b1, 24'($urandom)};
        if (cat < 2) begin
            Ez_add = 10'(0 - int'($urandom_range(0, 5)));
            normalised_output[24] = 1'b0;
        end else if (cat == 2) begin
            Ez_add = 10'($urandom_range(240, 270));
        end else if (cat == 3) begin
            Ez_add = 10'($urandom_range(1, 35));
        end else begin
            Ez_add = 10'($urandom_range(1, 400));
        end
        if ($urandom_range(0, 7) == 0) normalised_output[23:1] = '1;
    endtask

    // Samples at the falling edge, then returns just after the next rising edge.
    task automatic step();
        @(negedge CLK);
        if (chk_ready) check("full_rate_in_ready", in_ready, 1);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else begin
                check("stream_result", {flags, result}, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
        end
        if (in_valid && in_ready)
            exp_q.push_back(model(sign_in, Ez_add, normalised_output, sticky_in, SHL, ovf));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vecs[0]  = '{0, 10'd127, 25'h1000000, 0, 5'd0,  0, 32'h3F800000, 3'b000};
        vecs[1]  = '{0, 10'd127, 25'h1000003, 0, 5'd0,  0, 32'h3F800002, 3'b001};
        vecs[2]  = '{0, 10'd127, 25'h1000001, 0, 5'd0,  0, 32'h3F800000, 3'b001};
        vecs[3]  = '{0, 10'd127, 25'h1FFFFFF, 0, 5'd0,  0, 32'h40000000, 3'b001};
        vecs[4]  = '{1, 10'd254, 25'h1000000, 0, 5'd0,  1, 32'hFF800000, 3'b101};
        vecs[5]  = '{0, 10'd127, 25'h1000001, 1, 5'd0,  0, 32'h3F800001, 3'b001};
        vecs[6]  = '{0, 10'd130, 25'h1400000, 0, 5'd3,  0, 32'h3FA00000, 3'b000};
        vecs[7]  = '{0, 10'd254, 25'h1000000, 0, 5'd0,  0, 32'h7F000000, 3'b000};
        vecs[8]  = '{0, 10'd254, 25'h1FFFFFF, 0, 5'd0,  0, 32'h7F800000, 3'b101};
        vecs[9]  = '{1, 10'd5,   25'h1000000, 0, 5'd10, 0, 32'h80000000, 3'b011};
        vecs[10] = '{0, 10'd0,   25'h0FFFFFF, 0, 5'd0,  0, 32'h00800000, 3'b001};
        vecs[11] = '{0, 10'h3FD, 25'h0000003, 0, 5'd0,  0, 32'h00000002, 3'b011};
        vecs[12] = '{0, 10'd1,   25'h1000000, 0, 5'd0,  0, 32'h00800000, 3'b000};
        vecs[13] = '{1, 10'h3FD, 25'h0000002, 0, 5'd0,  0, 32'h80000001, 3'b000};

        RST = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive_vec(0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", flags, 0);
        check("reset_in_ready", in_ready, 1);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Single transactions: latency and value per vector
        for (int i = 0; i < 14; i++) begin
            @(posedge CLK);
            #1;
            drive_vec(i);
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(negedge CLK);
            check("vec_in_ready", in_ready, 1);
            @(posedge CLK);
            #1;
            in_valid = 1'b0;
            @(negedge CLK);
            check("vec_latency_early", out_valid, 0);
            @(negedge CLK);
            check("vec_out_valid", out_valid, 1);
            check($sformatf("vec%0d_result", i), result, vecs[i].r);
            check($sformatf("vec%0d_flags", i), flags, vecs[i].f);
        end
        @(posedge CLK);
        #1;

        // Backpressure: two slots fill, then the pipe stalls with stable output
        begin
            int acc = 0;
            out_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) begin
                    @(posedge CLK);
                    #1;
                end
                drive_vec(k);
                in_valid = 1'b1;
                @(negedge CLK);
                if (in_valid && in_ready) acc++;
                if (k >= 2) check("bp_stall_result", result, vecs[0].r);
            end
            check("bp_accepted", acc, 2);
            check("bp_in_ready_low", in_ready, 0);
            @(posedge CLK);
            #1;
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(negedge CLK);
            check("bp_first_valid", out_valid, 1);
            check("bp_first_result", result, vecs[0].r);
            @(negedge CLK);
            check("bp_second_valid", out_valid, 1);
            check("bp_second_result", result, vecs[1].r);
            @(negedge CLK);
            check("bp_drained", out_valid, 0);
        end

        // Reset with both stages full
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        drive_vec(4);
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        drive_vec(5);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        @(negedge CLK);
        check("rst_pre_full_valid", out_valid, 1);
        check("rst_pre_full_in_ready", in_ready, 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_result", result, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("rst_no_stale", out_valid, 0);
        end
        @(posedge CLK);
        #1;

        // Full throughput streaming
        chk_ready = 1;
        popped = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_vec(k);
            step();
        end
        chk_ready = 0;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("full_rate_count", popped, 10);
        check("full_rate_queue_empty", exp_q.size(), 0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_inputs();
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        check("rand_drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/round_pack.md
ROUND_PACK -- requirements
Module: round_pack

Interface
REQ-001 SHALL have parameter EXP_W, default 10, width of signed unbiased-sum exponent input Ez_add.
REQ-002 SHALL have parameter MAX_EXP, default 255, exponent field value that encodes infinity.
REQ-003 CLK  input  1  single clock, all state rising-edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  normalization result presented.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 sign_in  input  1  product sign.
REQ-008 Ez_add  input  EXP_W  biased exponent sum, two's complement; bit 9 set or zero = subnormal path.
REQ-009 normalised_output  input  25  {hidden, frac[22:0], guard}.
REQ-010 sticky_in  input  1  OR of all product bits below guard.
REQ-011 SHL  input  5  left-shift count applied upstream; ovf  input  1  product MSB carry.
REQ-012 out_valid  output  1; out_ready  input  1; result  output  32  IEEE-754 single.
REQ-013 flags  output  3  {overflow, underflow, inexact}, valid with result.

Function
REQ-014 Two-stage pipeline, valid/ready on both ends; latency exactly 2 cycles from accepting edge to out_valid with no backpressure.
REQ-015 Stage 1 SHALL register: E = Ez_add + ovf - SHL (EXP_W+1 bits signed) on normal path; E = 0 on subnormal path; sign; 24-bit mantissa; round increment; inexact = guard | sticky_in.
REQ-016 Round-to-nearest-even increment = guard & (frac[0] | sticky_in).
REQ-017 Stage 2 SHALL add increment to 24-bit mantissa; carry-out shifts mantissa right 1 and increments E.
REQ-018 Subnormal path: hidden=0 input; if rounding carries into bit 23 (hidden), exponent field = 1.
REQ-019 E >= MAX_EXP after rounding: result = {sign, 8'hFF, 23'h0}, overflow=1, inexact=1.
REQ-020 E <= 0 on normal path (underflow past upstream shift): result = {sign, 31'h0}, underflow=1, inexact=1.
REQ-021 underflow=1 also when exponent field is 0 and inexact=1; otherwise underflow=0.
REQ-022 Normal result = {sign, E[7:0], mantissa[22:0]}.
REQ-023 Stage advances when its downstream slot is empty or being consumed; in_ready = !s1_full | s1_advancing.
REQ-024 Full throughput: accept and emit every cycle while out_ready=1.
REQ-025 out_valid with out_ready=0: result and flags SHALL hold stable until handshake.
REQ-026 Simultaneous accept and emit on a full pipe: no bubble, no loss, order preserved.

Reset
REQ-027 RST=1 at a rising edge SHALL clear both stage valids, out_valid=0, result=0, flags=0, in_ready=1 next cycle.
REQ-028 Reset mid-operation SHALL discard in-flight data; no partial result emitted after release.

Configuration
REQ-029 Macro ROUND_MODES_EN: when defined, add input rm[1:0] (00 RNE, 01 RTZ, 10 RUP, 11 RDN), registered in stage 1 with the data.
REQ-030 With ROUND_MODES_EN: RTZ increment=0; RUP increment=inexact&!sign; RDN increment=inexact&sign; overflow under RTZ, or RUP with sign=1, or RDN with sign=0, yields {sign, 8'hFE, 23'h7FFFFF}.
REQ-031 Without ROUND_MODES_EN: no rm port, RNE only.

Verification
REQ-032 norm=25'h1000000, Ez_add=127, ovf=0, SHL=0, sticky=0 -> result 32'h3F800000, flags 3'b000, out_valid 2 cycles later.
REQ-033 norm=25'h1000003, Ez_add=127, sticky=0 -> 32'h3F800002, inexact=1; norm=25'h1000001 -> 32'h3F800000, inexact=1 (tie to even).
REQ-034 norm=25'h1FFFFFF, Ez_add=127 -> mantissa carry, result 32'h40000000, inexact=1.
REQ-035 Ez_add=254, ovf=1, sign=1 -> 32'hFF800000, flags 3'b101.
REQ-036 Backpressure: out_ready=0 for 4 cycles while in_valid=1 -> exactly 2 inputs accepted, in_ready=0 after, results in order and stable; then out_ready=1 -> one result per cycle.
REQ-037 RST asserted with both stages full -> out_valid=0 next cycle, no stale result after release.
